// File: rtl/bsg_fsb_ls_pkg.sv
// Shared definitions for the node-domain side of the FSB/node level-shift
// crossing: the isolation/wake state encoding and a helper that sizes the
// wake settle counter from the configured settle length.
package bsg_fsb_ls_pkg;

  typedef enum logic [1:0] {
    eActive,
    eDrain,
    eIsolated,
    eWake
  } ls_state_e;

  // Width needed to hold the settle count wake_cycles (counter loads the full
  // value and counts down to 1). Clamped to one bit for degenerate settings.
  function automatic int unsigned ls_ctr_width(input int unsigned wake_cycles);
    return (wake_cycles < 1) ? 1 : $clog2(wake_cycles + 1);
  endfunction

endpackage

// File: rtl/bsg_fsb_ls_two_fifo.sv
// Two-entry ready/valid FIFO used for both directions of the node-domain
// level-shift endpoint.
//
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   flush_i           discard all contents (wins over a same-cycle enq/deq)
//   enq_i, data_i     write a word; caller only asserts enq_i when !full_o
//   deq_i             drop the head; caller only asserts deq_i when !empty_o
//   data_o            head word, valid while !empty_o
//   empty_o, full_o   occupancy flags
//
// There is no bypass path: a word written in cycle N appears on data_o in
// cycle N+1, and a full FIFO never accepts even when the head leaves.
module bsg_fsb_ls_two_fifo
  import bsg_fsb_ls_pkg::*;
#(
  parameter int unsigned width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);

  logic [width_p-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (enq_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq_i) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq_i, deq_i})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign empty_o = (count == 2'd0);
  assign full_o  = (count == 2'd2);

  a_no_deq_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   deq_i |-> !empty_o);
  a_no_enq_full:  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   (enq_i && !flush_i) |-> !full_o);

endmodule

// File: rtl/bsg_fsb_node_level_shift_node_domain.sv
// Node-domain endpoint of the FSB/node level-shift crossing.
//
// Buffers f2n traffic (shifter -> core) and n2f traffic (core -> shifter) in
// two-entry FIFOs and sequences isolation so the FSB-side enable can drop
// without losing an accepted n2f word, followed by a counted settle period
// after the enable returns.
//
// Ports:
//   clk_i, reset_n_i          node clock, asynchronous active-low reset
//   en_ls_i                   level-shifter enable seen in the node domain
//   iso_req_i / iso_ack_o     isolation request / quiescent-and-isolated
//   ls_err_o                  sticky: enable dropped before a completed drain
//   ls_v_i/ls_data_i/ls_ready_o       f2n from shifter
//   core_v_o/core_data_o/core_yumi_i  f2n to core
//   core_v_i/core_data_i/core_ready_o n2f from core
//   ls_v_o/ls_data_o/ls_yumi_i        n2f to shifter
module bsg_fsb_node_level_shift_node_domain
  import bsg_fsb_ls_pkg::*;
#(
  parameter int unsigned width_p       = 5,
  parameter int unsigned wake_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_ls_i,
  input  logic               iso_req_i,
  output logic               iso_ack_o,
  output logic               ls_err_o,
  input  logic               ls_v_i,
  input  logic [width_p-1:0] ls_data_i,
  output logic               ls_ready_o,
  output logic               core_v_o,
  output logic [width_p-1:0] core_data_o,
  input  logic               core_yumi_i,
  input  logic               core_v_i,
  input  logic [width_p-1:0] core_data_i,
  output logic               core_ready_o,
  output logic               ls_v_o,
  output logic [width_p-1:0] ls_data_o,
  input  logic               ls_yumi_i
);

  localparam int unsigned ctr_width_lp = ls_ctr_width(wake_cycles_p);
  localparam logic [ctr_width_lp-1:0] wake_load_lp = ctr_width_lp'(wake_cycles_p);
  localparam logic [ctr_width_lp-1:0] ctr_one_lp   = ctr_width_lp'(1);

  ls_state_e               state_r, state_n;
  logic [ctr_width_lp-1:0] ctr_r, ctr_n;
  logic                    err_r, err_n;
  logic                    flush_out;

  logic in_enq, in_empty, in_full;
  logic out_enq, out_deq, out_empty, out_full, out_drained;

  // ---------------------------------------------------------------------------
  // Handshake gating
  // ---------------------------------------------------------------------------
  assign ls_ready_o   = (state_r == eActive) & ~in_full;
  assign in_enq       = ls_v_i & ls_ready_o;
  assign core_v_o     = ~in_empty;

  assign core_ready_o = (state_r == eActive) & ~out_full;
  assign out_enq      = core_v_i & core_ready_o;
  assign ls_v_o       = ~out_empty & ((state_r == eActive) | (state_r == eDrain));
  assign out_deq      = ls_yumi_i & ls_v_o;

  // The drain counts as complete in the cycle the last word is popped, so
  // isolation is acknowledged the cycle right after that pop.
  assign out_drained  = out_empty | (~out_full & out_deq);

  assign iso_ack_o    = (state_r == eIsolated);
  assign ls_err_o     = err_r;

  // ---------------------------------------------------------------------------
  // Isolation / wake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eWake;
      ctr_r   <= wake_load_lp;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      ctr_r   <= ctr_n;
      err_r   <= err_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    ctr_n     = ctr_r;
    err_n     = err_r;
    flush_out = 1'b0;
    case (state_r)
      eActive: begin
        if (!en_ls_i) begin
          state_n   = eIsolated;
          flush_out = 1'b1;
          err_n     = 1'b1;
        end else if (iso_req_i) begin
          state_n = eDrain;
        end
      end
      eDrain: begin
        if (out_drained) begin
          state_n = eIsolated;
        end else if (!en_ls_i) begin
          state_n   = eIsolated;
          flush_out = 1'b1;
          err_n     = 1'b1;
        end
      end
      eIsolated: begin
        if (!iso_req_i && en_ls_i) begin
          state_n = eWake;
          ctr_n   = wake_load_lp;
        end
      end
      eWake: begin
        if (en_ls_i && !iso_req_i) begin
          if (ctr_r == ctr_one_lp) begin
            state_n = eActive;
          end else begin
            ctr_n = ctr_r - ctr_one_lp;
          end
        end else begin
          state_n = eIsolated;
          ctr_n   = wake_load_lp;
        end
      end
      default: begin
        state_n = eIsolated;
        ctr_n   = wake_load_lp;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Buffers
  // ---------------------------------------------------------------------------
  bsg_fsb_ls_two_fifo #(.width_p(width_p)) inbound (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (1'b0),
    .enq_i     (in_enq),
    .data_i    (ls_data_i),
    .deq_i     (core_yumi_i),
    .data_o    (core_data_o),
    .empty_o   (in_empty),
    .full_o    (in_full)
  );

  bsg_fsb_ls_two_fifo #(.width_p(width_p)) outbound (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush_out),
    .enq_i     (out_enq),
    .data_i    (core_data_i),
    .deq_i     (out_deq),
    .data_o    (ls_data_o),
    .empty_o   (out_empty),
    .full_o    (out_full)
  );

endmodule
